mag_comp_seq: RTL and testbench
===============================

Name: mag_comp_seq

Overview:
- Sequential controller that compares two WIDTH-bit unsigned operands using one shared external 2-bit magnitude comparator slice.
- Walks the operands MSB-first, one 2-bit slice per cycle, and drives the slice onto the comparator.
- Samples the comparator's 3-bit result and reports the final relation with a start/done handshake.
- Lets wide compares reuse the existing 2-bit comparator instead of building a wide one.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- SLICES, WIDTH/2, derived; number of 2-bit slices. Not for override.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; accepted only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- busy  out  1  high from the cycle after acceptance until done falls.
- done  out  1  one-cycle pulse; x is valid from this cycle on.
- x  out  3  result: 100 = a>b, 010 = a==b, 001 = a<b, 000 = reset/error.
- cmp_a  out  2  current A slice to the external comparator.
- cmp_b  out  2  current B slice to the external comparator.
- cmp_x  in  3  comparator result, same encoding as x; combinational from cmp_a/cmp_b.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State IDLE; busy=0, done=0, x=000, cmp_a=00, cmp_b=00; index cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a and b into a_q and b_q, set idx=SLICES-1, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - cmp_a = a_q[2*idx+1:2*idx], cmp_b = b_q[2*idx+1:2*idx].
  - cmp_x is sampled each edge:
    - cmp_x=100 or 001: latch it as the result and go to DONE.
    - cmp_x=010 and idx=0: result=010, go to DONE.
    - cmp_x=010 and idx>0: decrement idx, stay in RUN.
    - Any other code (not one-hot): result=000, go to DONE (error).
- DONE:
  - done=1 for exactly one cycle; x updated to the result on entry.
  - Next cycle: back to IDLE.
- Outputs outside RUN:
  - cmp_a=cmp_b=00 in IDLE and DONE.
  - x holds its value until the next DONE or reset.
- busy: 1 in RUN and DONE, 0 in IDLE.
- Latency (start high in cycle 0; first unequal slice is k slices from the MSB, k=0..SLICES-1):
  - RUN occupies cycles 1..k+1; done=1 in cycle k+2.
  - Equal operands: done in cycle SLICES+1.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored; no queueing; a_q and b_q unchanged.
  - a and b may change after acceptance with no effect.
  - WIDTH=2: single RUN cycle; done in cycle 2.
  - rst mid-operation: abort; no done pulse; outputs return to reset values next cycle.
  - start and rst both high: reset wins.

Optional Feature:
- Macro: MAG_SEQ_EARLY_EXIT_EN.
- Defined: early termination as described above (variable latency).
- Undefined (constant latency):
  - Always scans all SLICES slices; the first non-010 cmp_x code is latched.
  - Later slices are ignored; the error code still latches 000.
  - done always in cycle SLICES+1.

Test Plan (WIDTH=8; bench instantiates the existing 2-bit comparator on cmp_a/cmp_b/cmp_x):
- Early exit, greater: a=8'hC0, b=8'h00, start in cycle 0 -> done=1 in cycle 2, x=100, busy high cycles 1-2.
- Equal: a=8'h5A, b=8'h5A -> done in cycle 5, x=010; cmp_a sequence 01,01,10,10.
- LSB slice decides: a=8'h12, b=8'h13 -> done in cycle 5, x=001; same result and cycle with macro undefined.
- Macro undefined: a=8'hFF, b=8'h00 -> done in cycle 5 (not 2), x=100.
- start re-asserted in cycle 1 with a=8'h00, b=8'hFF during an 8'hC0 vs 8'h00 compare -> ignored, x=100, single done pulse.
- rst=1 in cycle 2 of an equal-operand compare -> busy=0 and x=000 from cycle 3, no done; a new start then completes normally.

Source files
------------

// File: rtl/mag_comp_seq.sv
// MSB-first sequential magnitude compare of two WIDTH-bit operands through one
// shared external 2-bit comparator slice. Optional macro: MAG_SEQ_EARLY_EXIT_EN.
module mag_comp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       x,
  output logic [1:0]       cmp_a,
  output logic [1:0]       cmp_b,
  input  logic [2:0]       cmp_x,
  output logic [1:0]       dbg_state_o
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(SLICES - 1);

  localparam logic [2:0] GT  = 3'b100;
  localparam logic [2:0] EQ  = 3'b010;
  localparam logic [2:0] LT  = 3'b001;
  localparam logic [2:0] ERR = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             found_q, found_d;
  logic [2:0]       res_q, res_d;
  logic [2:0]       x_q, x_d;

  logic [2:0]       slice_code;
  logic [2:0]       res_now;
  logic             early_stop;
  logic [IDXW:0]    bit_base;
  logic [WIDTH-1:0] a_sh, b_sh;

  // Once a non-equal slice has been seen, its verdict is final; later slices
  // are only scanned (constant-latency build) and never change the result.
  always_comb begin
    slice_code = ERR;
    if (cmp_x == GT || cmp_x == LT || cmp_x == EQ) slice_code = cmp_x;
    res_now = found_q ? res_q : slice_code;
  end

`ifdef MAG_SEQ_EARLY_EXIT_EN
  assign early_stop = (cmp_x != EQ);
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      res_q   <= ERR;
      x_q     <= ERR;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      res_q   <= res_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    found_d = found_q;
    res_d   = res_q;
    x_d     = x_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          found_d = 1'b0;
          res_d   = EQ;
        end
      end
      S_RUN: begin
        res_d   = res_now;
        found_d = found_q | (cmp_x != EQ);
        if (idx_q == '0 || early_stop) begin
          state_d = S_DONE;
          x_d     = res_now;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bit_base = {idx_q, 1'b0};
  assign a_sh     = a_q >> bit_base;
  assign b_sh     = b_q >> bit_base;

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    cmp_a = 2'b00;
    cmp_b = 2'b00;
    case (state_q)
      S_RUN: begin
        busy  = 1'b1;
        cmp_a = a_sh[1:0];
        cmp_b = b_sh[1:0];
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign x           = x_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mag_comp_seq.sv
// Bench for mag_comp_seq (WIDTH=8): directed table, hand sequences for reset,
// re-start and comparator-error cases, and randomized compares against a model.
module tb_mag_comp_seq;
  localparam int W = 8;
  localparam int S = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [2:0]   x;
  logic [1:0]   cmp_a, cmp_b;
  logic [2:0]   cmp_x;
  logic [1:0]   dbg_state;
  logic         inj_bad = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_x = 3'b000;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Existing 2-bit comparator slice; inj_bad forces an illegal code.
  assign cmp_x = inj_bad ? 3'b011 :
                 (cmp_a > cmp_b) ? 3'b100 :
                 (cmp_a == cmp_b) ? 3'b010 : 3'b001;

  mag_comp_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .x(x),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_x(cmp_x),
    .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   x;
    int           lat_e;
    int           lat_c;
  } tv_t;

  tv_t tbl[8];

  function automatic logic [1:0] slice(input logic [W-1:0] v, input int i);
    int p;
    p = 1;
    for (int j = 0; j < S - 1 - i; j++) p = p * 4;
    return 2'((int'(v) / p) % 4);
  endfunction

  function automatic logic [2:0] ref_x(input logic [W-1:0] ra, input logic [W-1:0] rb);
    if (ra > rb) return 3'b100;
    if (ra == rb) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rb);
`ifdef MAG_SEQ_EARLY_EXIT_EN
    for (int i = 0; i < S; i++)
      if (slice(ra, i) != slice(rb, i)) return i + 2;
`endif
    return S + 1;
  endfunction

  function automatic int pick_lat(input int le, input int lc);
`ifdef MAG_SEQ_EARLY_EXIT_EN
    return le;
`else
    return lc;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic run_cmp(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic [2:0] ex, input int lat, input bit reassert);
    int got;
    int nd;
    logic [3:0] e;
    exp_q.delete();
    for (int i = 0; i < lat - 1; i++) exp_q.push_back({slice(ta, i), slice(tbv, i)});
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (reassert) begin
      start = 1'b1; a = 8'h00; b = 8'hFF;
    end
    got = -1; nd = 0;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (got < 0) got = cyc;
        chk({name, "_x_at_done"}, 32'(x), 32'(ex));
      end else if (cyc < lat) begin
        chk({name, "_x_hold"}, 32'(x), 32'(last_x));
      end
      chk({name, "_busy"}, 32'(busy), 32'(cyc <= lat));
      if (cyc < lat && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({name, "_cmp_a"}, 32'(cmp_a), 32'(e[3:2]));
        chk({name, "_cmp_b"}, 32'(cmp_b), 32'(e[1:0]));
      end else if (cyc >= lat) begin
        chk({name, "_cmp_idle"}, 32'({cmp_a, cmp_b}), 32'd0);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({name, "_done_cycle"}, 32'(got), 32'(lat));
    chk({name, "_done_pulses"}, 32'(nd), 32'd1);
    chk({name, "_x_after"}, 32'(x), 32'(ex));
    last_x = ex;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    tbl[0] = '{8'hC0, 8'h00, 3'b100, 2, 5};
    tbl[1] = '{8'h5A, 8'h5A, 3'b010, 5, 5};
    tbl[2] = '{8'h12, 8'h13, 3'b001, 5, 5};
    tbl[3] = '{8'hFF, 8'h00, 3'b100, 2, 5};
    tbl[4] = '{8'h40, 8'h80, 3'b001, 2, 5};
    tbl[5] = '{8'h0C, 8'h08, 3'b100, 4, 5};
    tbl[6] = '{8'h81, 8'h42, 3'b100, 2, 5};
    tbl[7] = '{8'h00, 8'h00, 3'b010, 5, 5};

    // Reset with start also high: reset wins.
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 8; i++)
      run_cmp($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].x,
              pick_lat(tbl[i].lat_e, tbl[i].lat_c), 1'b0);

    // Start re-asserted in cycle 1 with different operands is ignored.
    run_cmp("reassert", 8'hC0, 8'h00, 3'b100, ref_lat(8'hC0, 8'h00), 1'b1);

    // Illegal comparator code latches the error result.
    inj_bad = 1'b1;
    run_cmp("badcode", 8'h5A, 8'h5A, 3'b000, pick_lat(2, 5), 1'b0);
    inj_bad = 1'b0;
    run_cmp("recover", 8'hC0, 8'h00, 3'b100, ref_lat(8'hC0, 8'h00), 1'b0);

    // Reset in cycle 2 of an equal-operand compare aborts it.
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_x", 32'(x), 32'd0);
    chk("abort_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 6; c++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("abort_no_done", 32'(nd), 32'd0);
    end
    @(posedge clk); #1;
    last_x = 3'b000;
    run_cmp("after_abort", 8'h12, 8'h13, 3'b001, ref_lat(8'h12, 8'h13), 1'b0);

    // Randomized compares; every other one differs in a single slice only.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 255));
      if (n % 2 == 0) rb = ra ^ (W'($urandom_range(0, 3)) << (2 * $urandom_range(0, S - 1)));
      else rb = W'($urandom_range(0, 255));
      run_cmp($sformatf("rand%0d", n), ra, rb, ref_x(ra, rb), ref_lat(ra, rb), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
